htree_qinj_fanout: RTL and testbench
====================================

Name: htree_qinj_fanout

Overview:
- Parametrised successor to the H-tree charge-injection fan-out.
- Takes one 40 MHz-synchronous injection trigger and produces per-pixel ChargeInj pulses to NUM_PIX pixels.
- Pulse delay and width are programmable; a per-pixel enable mask is shadowed, a post-pulse holdoff is enforced, and accepted/dropped triggers are counted.
- Sits between the QInj module and the pixel matrix.

Parameters:
- NUM_PIX, 256, number of pixel outputs (any value ≥ 1).
- DLY_W, 5, width of QInjDelay; delay range 0..2^DLY_W-1 cycles.
- WID_W, 4, width of QInjWidth; pulse width 1..2^WID_W-1 cycles.
- HOLDOFF, 2, idle cycles forced after each pulse (0 allowed).
- CNT_W, 16, width of the accepted-trigger counter.

Ports:
- CLK40  input  1  40 MHz clock; all logic on the rising edge.
- RSTn  input  1  reset, asynchronous assert, active-low.
- QInjTrig  input  1  injection request, sampled each cycle, level-sensitive single-cycle pulse.
- QInjDelay  input  DLY_W  cycles from trigger acceptance to pulse start; sampled at acceptance.
- QInjWidth  input  WID_W  pulse width in cycles; sampled at acceptance.
- QInjMask  input  NUM_PIX  per-pixel enable, 1 = inject.
- MaskLoad  input  1  request to copy QInjMask into the active mask.
- ChargeInj_OUT  output  NUM_PIX  registered per-pixel injection pulses.
- Busy  output  1  high while not IDLE.
- TrigCount  output  CNT_W  accepted triggers, saturating.
- DropCount  output  8  triggers ignored while busy, saturating.

Behaviour:
- Reset (RSTn low, async):
  - ChargeInj_OUT = 0, Busy = 0, TrigCount = 0, DropCount = 0.
  - Active mask = all ones; pending-load flag = 0; FSM = IDLE.
- FSM states: IDLE, DELAY, PULSE, HOLD.
- IDLE:
  - QInjTrig=1 → accept: latch delay d and width w (w=0 is treated as 1), TrigCount+1.
  - Next state is DELAY if d>0, else PULSE.
- DELAY: counts d cycles, then PULSE.
- PULSE: ChargeInj_OUT = active mask for exactly w cycles. Then HOLD if HOLDOFF>0, else IDLE.
- HOLD: counts HOLDOFF cycles, then IDLE.
- Latency, for a trigger sampled at edge T:
  - ChargeInj_OUT goes high at edge T+1+d and falls at edge T+1+d+w.
  - Busy is registered: 1 from edge T+1 until the edge ending the last HOLD cycle.
  - The earliest next acceptance is at edge T+1+d+w+HOLDOFF.
- QInjTrig while not IDLE: ignored; DropCount+1 (saturates at 255). No queuing.
- MaskLoad:
  - In IDLE with no trigger, the mask copies at the next edge.
  - If MaskLoad is asserted while busy, or coincides with an accepted trigger, the pending flag sets. The copy occurs on the transition into IDLE, and the flag clears.
  - The active mask never changes during a pulse. The pulse in progress uses the mask at acceptance time.
- QInjDelay/QInjWidth changes after acceptance have no effect on the current pulse.
- Counters saturate at all-ones and do not wrap.
- Reset mid-pulse: outputs drop immediately (asynchronous) and the FSM returns to IDLE. Any pending mask load is discarded.
- All ChargeInj_OUT bits come from flops. No combinational path from QInjTrig to the outputs.

Decomposition:
- Shared package htree_pkg holds:
  - the enum qinj_state_t {IDLE, DELAY, PULSE, HOLD};
  - default constants NUM_PIX_DEF=256 and HOLDOFF_DEF=2.
- Sub-module qinj_pulse_seq holds the FSM, delay/width/holdoff counter, Busy and the counters. It outputs a single pulse_en and an at_idle strobe.
- The top holds the active mask, the pending-load flag and the NUM_PIX output register (pulse_en AND mask).

Test Plan:
1. Reset, mask all ones, d=3, w=2, trigger at edge 10 → all 256 outputs high at edges 14–15, low at 16; Busy high for edges 11–17; TrigCount=1.
2. d=0, w=0 → pulse starts at T+1 and lasts exactly 1 cycle (w forced to 1).
3. Trigger during DELAY and twice during HOLD → no extra pulses; DropCount=3; next trigger after IDLE is accepted.
4. Mask 0x…00FF loaded in IDLE, then trigger → only pixels 0–7 pulse. MaskLoad of 0x…FF00 mid-PULSE → the current pulse still uses 0x…00FF, and the next pulse hits pixels 8–15.
5. RSTn dropped during PULSE → outputs 0 asynchronously; Busy=0; counters=0; mask all ones; the pending load is lost.
6. Issue 2^CNT_W+5 spaced triggers (force CNT_W=4) → TrigCount holds at 15. Issue 300 drops → DropCount holds at 255.

Source files
------------

// File: rtl/htree_qinj_fanout_pkg.sv
// Shared types and defaults for the H-tree charge-injection fan-out.
package htree_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } qinj_state_t;

  localparam int NUM_PIX_DEF = 256;
  localparam int HOLDOFF_DEF = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/htree_qinj_fanout_if.sv
// Trigger/config/observation bundle between QInj module and the fan-out.
interface htree_qinj_fanout_if #(
  parameter int NUM_PIX = 256,
  parameter int DLY_W   = 5,
  parameter int WID_W   = 4,
  parameter int CNT_W   = 16
);
  logic               QInjTrig;
  logic [DLY_W-1:0]   QInjDelay;
  logic [WID_W-1:0]   QInjWidth;
  logic [NUM_PIX-1:0] QInjMask;
  logic               MaskLoad;
  logic [NUM_PIX-1:0] ChargeInj_OUT;
  logic               Busy;
  logic [CNT_W-1:0]   TrigCount;
  logic [7:0]         DropCount;

  modport master (
    output QInjTrig, QInjDelay, QInjWidth, QInjMask, MaskLoad,
    input  ChargeInj_OUT, Busy, TrigCount, DropCount
  );

  modport slave (
    input  QInjTrig, QInjDelay, QInjWidth, QInjMask, MaskLoad,
    output ChargeInj_OUT, Busy, TrigCount, DropCount
  );
endinterface

// File: rtl/htree_qinj_fanout_pulse_seq.sv
// Injection sequencer: delay / pulse / holdoff timing, busy flag, trigger counters.
//   state | meaning
//   IDLE  | waiting for a trigger, mask may be reloaded
//   DELAY | counting programmed delay before the pulse
//   PULSE | pulse_en asserted for the latched width
//   HOLD  | forced quiet time before the next acceptance
module qinj_pulse_seq
  import htree_pkg::*;
#(
  parameter int DLY_W   = 5,
  parameter int WID_W   = 4,
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic [DLY_W-1:0] dly,
  input  logic [WID_W-1:0] wid,
  output logic             pulse_en,
  output logic             at_idle,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [7:0]       drop_count
);
  localparam int HLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int CW    = max_int(max_int(DLY_W, WID_W), HLD_W);
  localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  qinj_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WID_W-1:0] wid_q, wid_eff;
  logic             cnt_zero, accept, drop;

  assign wid_eff  = (wid == '0) ? WID_W'(1) : wid;
  assign cnt_zero = (cnt_q == '0);
  assign accept   = (state_q == IDLE) && trig;
  assign drop     = (state_q != IDLE) && trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = (dly != '0) ? DELAY : PULSE;
      DELAY:   if (cnt_zero) state_d = PULSE;
      PULSE:   if (cnt_zero) state_d = (HOLDOFF > 0) ? HOLD : IDLE;
      HOLD:    if (cnt_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // at_idle marks an edge where the active mask may legally change:
  // quiet IDLE, or the edge that returns the FSM to IDLE.
  always_comb begin
    pulse_en = (state_q == PULSE);
    at_idle  = (state_q == IDLE) ? !trig : (state_d == IDLE);
  end

  // Counter is loaded with (n-1) and each phase ends when it reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wid_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (trig) begin
          wid_q <= wid_eff;
          cnt_q <= (dly != '0) ? CW'(dly) - CW'(1) : CW'(wid_eff) - CW'(1);
        end
        DELAY:   cnt_q <= cnt_zero ? CW'(wid_q) - CW'(1) : cnt_q - CW'(1);
        PULSE:   cnt_q <= cnt_zero ? HOLD_LOAD : cnt_q - CW'(1);
        default: cnt_q <= cnt_zero ? '0 : cnt_q - CW'(1);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      trig_count <= '0;
      drop_count <= '0;
    end else begin
      busy <= (state_q != IDLE);
      if (accept && (trig_count != '1)) trig_count <= trig_count + CNT_W'(1);
      if (drop && (drop_count != '1))   drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: rtl/htree_qinj_fanout.sv
// Charge-injection fan-out: shadowed pixel mask gating a registered pulse to NUM_PIX pixels.
module htree_qinj_fanout
  import htree_pkg::*;
#(
  parameter int NUM_PIX = NUM_PIX_DEF,
  parameter int DLY_W   = 5,
  parameter int WID_W   = 4,
  parameter int HOLDOFF = HOLDOFF_DEF,
  parameter int CNT_W   = 16
) (
  input  logic               CLK40,
  input  logic               RSTn,
  htree_qinj_fanout_if.slave bus
);
  logic [NUM_PIX-1:0] mask_q, out_q;
  logic               pend_q, pulse_en, at_idle;

  qinj_pulse_seq #(
    .DLY_W   (DLY_W),
    .WID_W   (WID_W),
    .HOLDOFF (HOLDOFF),
    .CNT_W   (CNT_W)
  ) u_seq (
    .clk        (CLK40),
    .rst_n      (RSTn),
    .trig       (bus.QInjTrig),
    .dly        (bus.QInjDelay),
    .wid        (bus.QInjWidth),
    .pulse_en   (pulse_en),
    .at_idle    (at_idle),
    .busy       (bus.Busy),
    .trig_count (bus.TrigCount),
    .drop_count (bus.DropCount)
  );

  // Loads requested outside a safe window are deferred until the return to IDLE.
  always_ff @(posedge CLK40 or negedge RSTn) begin
    if (!RSTn) begin
      mask_q <= '1;
      pend_q <= 1'b0;
    end else if (at_idle) begin
      if (bus.MaskLoad || pend_q) mask_q <= bus.QInjMask;
      pend_q <= 1'b0;
    end else if (bus.MaskLoad) begin
      pend_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK40 or negedge RSTn) begin
    if (!RSTn) out_q <= '0;
    else       out_q <= pulse_en ? mask_q : '0;
  end

  assign bus.ChargeInj_OUT = out_q;

endmodule

// File: tb/tb_htree_qinj_fanout.sv
// Directed bench for htree_qinj_fanout: timing, drops, mask shadowing, reset, saturation.
module tb_htree_qinj_fanout;
  localparam int NP = 256;
  localparam int DW = 5;
  localparam int WW = 4;
  localparam int HO = 2;
  localparam int CW = 4;
  localparam logic [NP-1:0] ONES   = '1;
  localparam logic [NP-1:0] M_LO   = 256'hFF;
  localparam logic [NP-1:0] M_HI   = 256'hFF00;
  localparam logic [NP-1:0] M_JUNK = 256'hF0;

  logic CLK40 = 1'b0;
  logic RSTn  = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #10 CLK40 = ~CLK40;

  htree_qinj_fanout_if #(.NUM_PIX(NP), .DLY_W(DW), .WID_W(WW), .CNT_W(CW)) bus ();

  htree_qinj_fanout #(
    .NUM_PIX (NP),
    .DLY_W   (DW),
    .WID_W   (WW),
    .HOLDOFF (HO),
    .CNT_W   (CW)
  ) dut (
    .CLK40 (CLK40),
    .RSTn  (RSTn),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK40);
    #1;
  endtask

  // One accepted trigger from IDLE; checks pulse and Busy every cycle until idle again.
  task automatic trig_run(input logic [DW-1:0] d, input logic [WW-1:0] w,
                          input logic [NP-1:0] m, input string tag);
    int we, last;
    we   = (w == '0) ? 1 : int'(w);
    last = int'(d) + we + HO;
    bus.QInjDelay = d;
    bus.QInjWidth = w;
    bus.QInjTrig  = 1'b1;
    step();
    bus.QInjTrig  = 1'b0;
    bus.QInjDelay = ~d;
    bus.QInjWidth = ~w;
    for (int k = 1; k <= last + 1; k++) begin
      step();
      chk($sformatf("%s_out_k%0d", tag, k), bus.ChargeInj_OUT,
          (k >= 1 + int'(d) && k <= int'(d) + we) ? m : '0);
      chk($sformatf("%s_busy_k%0d", tag, k), NP'(bus.Busy), NP'(k <= last));
    end
  endtask

  initial begin
    bus.QInjTrig  = 1'b0;
    bus.QInjDelay = '0;
    bus.QInjWidth = '0;
    bus.QInjMask  = ONES;
    bus.MaskLoad  = 1'b0;

    // reset state
    #5;
    chk("rst_out", bus.ChargeInj_OUT, '0);
    chk("rst_busy", NP'(bus.Busy), '0);
    chk("rst_tc", NP'(bus.TrigCount), '0);
    chk("rst_dc", NP'(bus.DropCount), '0);
    @(negedge CLK40);
    RSTn = 1'b1;
    step();

    // 1: d=3 w=2, all-ones mask
    trig_run(5'd3, 4'd2, ONES, "t1");
    chk("t1_tc", NP'(bus.TrigCount), NP'(1));

    // 2: d=0 w=0 behaves as w=1
    trig_run(5'd0, 4'd0, ONES, "t2");
    chk("t2_tc", NP'(bus.TrigCount), NP'(2));

    // 3: drops during DELAY and HOLD, then earliest re-acceptance
    bus.QInjDelay = 5'd2;
    bus.QInjWidth = 4'd1;
    bus.QInjTrig  = 1'b1;
    step();                                   // T accepted
    step();                                   // T+1 dropped (DELAY)
    chk("t3_dc1", NP'(bus.DropCount), NP'(1));
    bus.QInjTrig = 1'b0;
    step();
    chk("t3_out_t2", bus.ChargeInj_OUT, '0);
    step();
    chk("t3_out_t3", bus.ChargeInj_OUT, ONES);
    bus.QInjTrig = 1'b1;
    step();                                   // T+4 dropped (HOLD)
    chk("t3_out_t4", bus.ChargeInj_OUT, '0);
    step();                                   // T+5 dropped (HOLD)
    step();                                   // T+6 accepted
    bus.QInjTrig = 1'b0;
    chk("t3_dc3", NP'(bus.DropCount), NP'(3));
    chk("t3_tc4", NP'(bus.TrigCount), NP'(4));
    step();
    chk("t3_out_t7", bus.ChargeInj_OUT, '0);
    step();
    chk("t3_out_t8", bus.ChargeInj_OUT, '0);
    step();
    chk("t3_out_t9", bus.ChargeInj_OUT, ONES);
    step();
    chk("t3_out_t10", bus.ChargeInj_OUT, '0);
    step();
    chk("t3_busy_t11", NP'(bus.Busy), NP'(1));
    step();
    chk("t3_busy_t12", NP'(bus.Busy), '0);

    // 4: mask load in IDLE, then deferred load during PULSE
    bus.QInjMask = M_LO;
    bus.MaskLoad = 1'b1;
    step();
    bus.MaskLoad  = 1'b0;
    bus.QInjDelay = 5'd1;
    bus.QInjWidth = 4'd3;
    bus.QInjTrig  = 1'b1;
    step();                                   // T
    bus.QInjTrig = 1'b0;
    step();
    chk("t4_out_t1", bus.ChargeInj_OUT, '0);
    step();
    chk("t4_out_t2", bus.ChargeInj_OUT, M_LO);
    bus.QInjMask = M_HI;
    bus.MaskLoad = 1'b1;
    step();
    bus.MaskLoad = 1'b0;
    chk("t4_out_t3", bus.ChargeInj_OUT, M_LO);
    step();
    chk("t4_out_t4", bus.ChargeInj_OUT, M_LO);
    step();
    chk("t4_out_t5", bus.ChargeInj_OUT, '0);
    step();
    step();
    chk("t4_busy_t7", NP'(bus.Busy), '0);
    trig_run(5'd0, 4'd1, M_HI, "t4b");

    // 5: reset mid-pulse with a pending load
    bus.QInjMask  = M_JUNK;
    bus.MaskLoad  = 1'b1;
    bus.QInjDelay = 5'd0;
    bus.QInjWidth = 4'd3;
    bus.QInjTrig  = 1'b1;
    step();
    bus.QInjTrig = 1'b0;
    bus.MaskLoad = 1'b0;
    step();
    chk("t5_out_pre", bus.ChargeInj_OUT, M_HI);
    #3;
    RSTn = 1'b0;
    #1;
    chk("t5_out_async", bus.ChargeInj_OUT, '0);
    chk("t5_busy", NP'(bus.Busy), '0);
    chk("t5_tc", NP'(bus.TrigCount), '0);
    chk("t5_dc", NP'(bus.DropCount), '0);
    @(negedge CLK40);
    RSTn = 1'b1;
    step();
    trig_run(5'd0, 4'd1, ONES, "t5a");
    trig_run(5'd0, 4'd1, ONES, "t5b");

    // 6: counter saturation
    bus.QInjDelay = 5'd0;
    bus.QInjWidth = 4'd1;
    for (int i = 0; i < 21; i++) begin
      bus.QInjTrig = 1'b1;
      step();
      bus.QInjTrig = 1'b0;
      step();
      step();
      step();
      if (i == 11) chk("t6_tc14", NP'(bus.TrigCount), NP'(14));
    end
    chk("t6_tc_sat", NP'(bus.TrigCount), NP'(15));
    bus.QInjDelay = 5'd31;
    bus.QInjWidth = 4'd15;
    bus.QInjTrig  = 1'b1;
    for (int i = 0; i < 330; i++) step();
    bus.QInjTrig = 1'b0;
    chk("t6_dc_sat", NP'(bus.DropCount), NP'(255));
    chk("t6_tc_hold", NP'(bus.TrigCount), NP'(15));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
